// File: rtl/apu_pkg.sv
// Shared constants and state encodings for the APU pulse-channel serial loader.
package apu_pkg;

  localparam logic [7:0] HDR_MASK = 8'hFC;
  localparam logic [7:0] HDR_VAL  = 8'h80;

  localparam logic [1:0] ADDR_4000 = 2'd0;
  localparam logic [1:0] ADDR_4001 = 2'd1;
  localparam logic [1:0] ADDR_4002 = 2'd2;
  localparam logic [1:0] ADDR_4003 = 2'd3;

  // RX_BREAK holds off after a framing error until the line returns high.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic {
    PS_WAIT_HDR,
    PS_WAIT_DATA
  } ps_state_e;

  function automatic logic is_header(input logic [7:0] b);
    return (b & HDR_MASK) == HDR_VAL;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver oversampled by clk: 2-flop synchronizer, mid-bit sampling,
// one-clk byte_valid / frame_err strobes.
module uart_rx
  import apu_pkg::*;
#(
  parameter int DIVISOR = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(DIVISOR / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  generate
    if (DIVISOR < 4) begin : g_bad_divisor
      $error("uart_rx: DIVISOR must be at least 4");
    end
  endgenerate

  logic            sync1_q, sync2_q;
  logic            sdi_s;
  rx_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_valid_q;
  logic            frame_err_q;

  // Synchronizer presets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sdi;
      sync2_q <= sync1_q;
    end
  end

  assign sdi_s = sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!sdi_s) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == CNT_MID) begin
            cnt_q <= '0;
            if (sdi_s) begin
              state_q <= RX_IDLE;
            end else begin
              state_q <= RX_DATA;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sdi_s, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              state_q <= RX_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          // Leaving at mid-stop lets a back-to-back start bit be caught.
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (sdi_s) begin
              byte_valid_q <= 1'b1;
              state_q      <= RX_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= RX_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_BREAK: begin
          if (sdi_s) begin
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_data  = shift_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/apu_serial_loader.sv
// Serial loader for the APU pulse-channel registers: a header byte 1000_00aa
// selects reg_40{aa}, the following byte is written to it.
module apu_serial_loader
  import apu_pkg::*;
#(
  parameter int CLKRATE  = 4800,
  parameter int BAUDRATE = 300,
  parameter int DIVISOR  = CLKRATE / BAUDRATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sdi,
  output logic [7:0] reg_4000,
  output logic [7:0] reg_4001,
  output logic [7:0] reg_4002,
  output logic [7:0] reg_4003,
  output logic       reg_change,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  uart_rx #(
    .DIVISOR(DIVISOR)
  ) u_uart_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .sdi       (sdi),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (rx_frame_err)
  );

  ps_state_e  ps_q;
  logic [1:0] addr_q;
  logic [7:0] regs_q [4];
  logic       reg_change_q;

  // A framing error discards any half-received packet so the next byte is a header candidate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_q         <= PS_WAIT_HDR;
      addr_q       <= '0;
      regs_q       <= '{default: 8'h00};
      reg_change_q <= 1'b0;
    end else begin
      reg_change_q <= 1'b0;
      if (rx_frame_err) begin
        ps_q <= PS_WAIT_HDR;
      end else if (rx_valid) begin
        case (ps_q)
          PS_WAIT_HDR: begin
            if (is_header(rx_byte)) begin
              addr_q <= rx_byte[1:0];
              ps_q   <= PS_WAIT_DATA;
            end
          end
          PS_WAIT_DATA: begin
            regs_q[addr_q] <= rx_byte;
            reg_change_q   <= 1'b1;
            ps_q           <= PS_WAIT_HDR;
          end
          default: ps_q <= PS_WAIT_HDR;
        endcase
      end
    end
  end

  assign reg_4000   = regs_q[ADDR_4000];
  assign reg_4001   = regs_q[ADDR_4001];
  assign reg_4002   = regs_q[ADDR_4002];
  assign reg_4003   = regs_q[ADDR_4003];
  assign reg_change = reg_change_q;
  assign frame_err  = rx_frame_err;

endmodule
